lcd_read_ci: RTL and testbench

//  Nios II multi-cycle custom instruction reading from the HD44780 character LCD: busy flag + address counter (RS=0) or data RAM (RS=1).

---
 rtl/lcd_pkg.sv | 34 +++
 rtl/lcd_phase_timer.sv | 36 +++
 rtl/lcd_read_ci.sv | 164 ++++++++++++++++
 tb/tb_lcd_read_ci.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared encodings and timing defaults for the HD44780 LCD
//               custom instructions (read and write).
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } lcd_state_e;

    localparam logic RS_INSTR = 1'b0;
    localparam logic RS_DATA  = 1'b1;
    localparam int   BF_BIT   = 7;

    localparam int LCD_SETUP_CYCLES = 50;
    localparam int LCD_PULSE_CYCLES = 25;
    localparam int LCD_HOLD_CYCLES  = 50;
    localparam int LCD_POLL_LIMIT   = 100000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_phase_timer
// Description : Loadable down-counter for LCD bus phases; terminal_count is
//               high when the count has reached zero. Holds when clk_en=0.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_phase_timer #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             terminal_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clk_en) begin
            if (load) begin
                r_count <= load_value;
            end else if (r_count != '0) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign terminal_count = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/lcd_read_ci.sv
`default_nettype none
// ============================================================================
// Module      : lcd_read_ci
// Description : Nios II multi-cycle custom instruction that performs one
//               HD44780 read cycle (busy flag/address or data RAM).
//               Optional busy polling is enabled by defining LCD_BUSY_POLL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_read_ci
    import lcd_pkg::*;
#(
    parameter int SETUP_CYCLES = LCD_SETUP_CYCLES,
    parameter int PULSE_CYCLES = LCD_PULSE_CYCLES,
    parameter int HOLD_CYCLES  = LCD_HOLD_CYCLES,
    parameter int POLL_LIMIT   = LCD_POLL_LIMIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    output logic [31:0] result,
    output logic        done,
    output logic        register_select,
    output logic        read_write,
    output logic        enable_op,
    input  logic [7:0]  data_in
);

    localparam int c_cnt_w = $clog2(max3(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES) + 1);
    localparam logic [c_cnt_w-1:0] c_setup_load = c_cnt_w'(SETUP_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_pulse_load = c_cnt_w'(PULSE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_hold_load  = c_cnt_w'(HOLD_CYCLES - 1);

    lcd_state_e         r_state;
    logic [7:0]         r_byte_read;
    logic               w_tc;
    logic               w_load;
    logic [c_cnt_w-1:0] w_load_value;
    logic               w_retry;
    logic               w_timeout;

`ifdef LCD_BUSY_POLL_EN
    localparam int c_poll_w = $clog2(POLL_LIMIT + 1);
    localparam logic [c_poll_w-1:0] c_poll_max = c_poll_w'(POLL_LIMIT);

    logic                r_poll_mode;
    logic [c_poll_w-1:0] r_poll_count;
    logic                w_bf_set;
    logic                w_unused_bits;

    // r_poll_count holds the number of completed read cycles when HOLD ends
    assign w_bf_set      = r_poll_mode && r_byte_read[BF_BIT];
    assign w_retry       = w_bf_set && (r_poll_count < c_poll_max);
    assign w_timeout     = w_bf_set && (r_poll_count >= c_poll_max);
    assign w_unused_bits = ^{dataB, dataA[31:2]};
`else
    logic w_unused_bits;

    assign w_retry       = 1'b0;
    assign w_timeout     = 1'b0;
    assign w_unused_bits = ^{dataB, dataA[31:1], (POLL_LIMIT > 0)};
`endif

    always_comb begin
        w_load       = 1'b0;
        w_load_value = c_setup_load;
        case (r_state)
            ST_IDLE:  w_load = start;
            ST_SETUP: begin
                w_load       = w_tc;
                w_load_value = c_pulse_load;
            end
            ST_PULSE: begin
                w_load       = w_tc;
                w_load_value = c_hold_load;
            end
            ST_HOLD:  w_load = w_tc && w_retry;
            default:  w_load = 1'b0;
        endcase
    end

    lcd_phase_timer #(
        .WIDTH(c_cnt_w)
    ) u_phase_timer (
        .clk           (clk),
        .reset         (reset),
        .clk_en        (clk_en),
        .load          (w_load),
        .load_value    (w_load_value),
        .terminal_count(w_tc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state         <= ST_IDLE;
            r_byte_read     <= 8'd0;
            result          <= 32'd0;
            done            <= 1'b0;
            register_select <= 1'b0;
            read_write      <= 1'b0;
            enable_op       <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
            r_poll_mode     <= 1'b0;
            r_poll_count    <= '0;
`endif
        end else if (clk_en) begin
            case (r_state)
                ST_IDLE: begin
                    done       <= 1'b0;
                    enable_op  <= 1'b0;
                    read_write <= 1'b0;
                    if (start) begin
                        register_select <= dataA[0] ? RS_DATA : RS_INSTR;
                        read_write      <= 1'b1;
                        r_state         <= ST_SETUP;
`ifdef LCD_BUSY_POLL_EN
                        r_poll_mode     <= dataA[1] && (dataA[0] == RS_INSTR);
                        r_poll_count    <= '0;
`endif
                    end
                end
                ST_SETUP: begin
                    if (w_tc) begin
                        enable_op <= 1'b1;
                        r_state   <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (w_tc) begin
                        r_byte_read <= data_in;
                        enable_op   <= 1'b0;
                        r_state     <= ST_HOLD;
`ifdef LCD_BUSY_POLL_EN
                        if (r_poll_count != c_poll_max) begin
                            r_poll_count <= r_poll_count + 1'b1;
                        end
`endif
                    end
                end
                ST_HOLD: begin
                    if (w_tc) begin
                        if (w_retry) begin
                            r_state <= ST_SETUP;
                        end else begin
                            result     <= {w_timeout, 23'd0, r_byte_read};
                            done       <= 1'b1;
                            read_write <= 1'b0;
                            r_state    <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_read_ci.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_read_ci
// Description : Scoreboard bench for lcd_read_ci with a behavioural model of
//               the read/poll sequence; honours LCD_BUSY_POLL_EN if defined.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lcd_read_ci;

    localparam int TB_POLL_LIMIT = 4;
    localparam int T_SETUP = 50;
    localparam int T_PULSE = 25;
    localparam int T_HOLD  = 50;
`ifdef LCD_BUSY_POLL_EN
    localparam bit POLL_FEATURE = 1'b1;
`else
    localparam bit POLL_FEATURE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_en = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dataA = 32'd0;
    logic [31:0] dataB = 32'd0;
    logic [7:0]  data_in = 8'd0;
    logic [31:0] result;
    logic        done;
    logic        register_select;
    logic        read_write;
    logic        enable_op;

    lcd_read_ci #(
        .SETUP_CYCLES(T_SETUP),
        .PULSE_CYCLES(T_PULSE),
        .HOLD_CYCLES (T_HOLD),
        .POLL_LIMIT  (TB_POLL_LIMIT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .clk_en         (clk_en),
        .start          (start),
        .dataA          (dataA),
        .dataB          (dataB),
        .result         (result),
        .done           (done),
        .register_select(register_select),
        .read_write     (read_write),
        .enable_op      (enable_op),
        .data_in        (data_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          reads;
        logic        rs;
        int          start_cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] byte_q[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: a busy poll keeps reading while BF is set, up to the limit
    function automatic exp_t model(input logic [31:0] a, input int freeze);
        exp_t e;
        int   n;
        bit   poll;
        logic to;
        poll = POLL_FEATURE && a[1] && !a[0];
        n = 1;
        while (poll && byte_q[n-1][7] && n < TB_POLL_LIMIT) n++;
        to = poll && byte_q[n-1][7];
        e.reads     = n;
        e.rs        = a[0];
        e.res       = {to, 23'd0, byte_q[n-1]};
        e.lat       = (T_SETUP + T_PULSE + T_HOLD) * n + 1 + freeze;
        e.start_cyc = cyc;
        return e;
    endfunction

    // Monitor / LCD responder, sampled 1 ns after the active edge
    exp_t        mon_e;
    int          e_hi_cnt = 0;
    int          pulses = 0;
    bit          e_prev = 1'b0;
    bit          rw_bad = 1'b0;
    bit          frz_bad = 1'b0;
    bit          res_bad = 1'b0;
    logic [31:0] last_res = 32'd0;
    logic [35:0] prev_out = 36'd0;

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            e_hi_cnt = 0;
            e_prev   = 1'b0;
            pulses   = 0;
            rw_bad   = 1'b0;
            frz_bad  = 1'b0;
            res_bad  = 1'b0;
            last_res = 32'd0;
        end else begin
            if (!clk_en && prev_out !== {result, done, register_select, read_write, enable_op})
                frz_bad = 1'b1;
            if (read_write !== ((exp_q.size() > 0) && !done))
                rw_bad = 1'b1;
            if (enable_op && !e_prev) begin
                pulses++;
                e_hi_cnt = 0;
                if (exp_q.size() > 0) check("rs_at_e_rise", 32'(register_select), 32'(exp_q[0].rs));
                else                  check("e_without_read", 32'(enable_op), 32'd0);
            end
            if (enable_op) begin
                e_hi_cnt++;
                if (byte_q.size() > 0) data_in = byte_q[0];
            end else begin
                if (e_prev) begin
                    check("e_width", 32'(e_hi_cnt), 32'(T_PULSE));
                    if (byte_q.size() > 0) void'(byte_q.pop_front());
                end
                data_in = 8'($urandom);
            end
            e_prev = enable_op;
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("result", result, mon_e.res);
                    check("latency", 32'(cyc - mon_e.start_cyc), 32'(mon_e.lat));
                    check("e_pulses", 32'(pulses), 32'(mon_e.reads));
                    check("rw_window", 32'(rw_bad), 32'd0);
                    check("frozen_outputs", 32'(frz_bad), 32'd0);
                    check("result_hold", 32'(res_bad), 32'd0);
                    last_res = mon_e.res;
                    pulses   = 0;
                    rw_bad   = 1'b0;
                    frz_bad  = 1'b0;
                    res_bad  = 1'b0;
                end
            end else if (result !== last_res) begin
                res_bad = 1'b1;
            end
        end
        prev_out = {result, done, register_select, read_write, enable_op};
    end

    task automatic load_bytes(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        byte_q.delete();
        byte_q.push_back(b0);
        byte_q.push_back(b1);
        byte_q.push_back(b2);
        byte_q.push_back(b3);
    endtask

    task automatic rand_bytes();
        int         run;
        logic [7:0] b;
        run = $urandom_range(0, TB_POLL_LIMIT);
        byte_q.delete();
        for (int k = 0; k < TB_POLL_LIMIT; k++) begin
            b = 8'($urandom);
            if (k < run)       b[7] = 1'b1;
            else if (k == run) b[7] = 1'b0;
            byte_q.push_back(b);
        end
    endtask

    task automatic finish_now();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    // Called just after a falling edge; returns just after a falling edge
    task automatic issue(input logic [31:0] a, input int freeze, input bit spur, input bit b2b);
        exp_t e;
        int   bound;
        bit   seen;
        e = model(a, freeze);
        exp_q.push_back(e);
        start = 1'b1;
        dataA = a;
        dataB = $urandom;
        @(negedge clk);
        start = 1'b0;
        dataA = $urandom;
        dataB = $urandom;
        if (freeze > 0) begin
            repeat (5) @(negedge clk);
            clk_en = 1'b0;
            repeat (freeze) @(negedge clk);
            clk_en = 1'b1;
        end
        if (spur) begin
            seen = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
                @(negedge clk);
                if (enable_op) seen = 1'b1;
            end
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        bound = e.lat + 50;
        seen  = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: no done within %0d cycles, expected after %0d", bound, e.lat);
            finish_now();
        end
        byte_q.delete();
        if (b2b) begin
            start = 1'b1;
            dataA = $urandom;
        end
        @(negedge clk);
        start = 1'b0;
        if (!b2b) repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    initial begin : stim
        exp_t e;
        bit   seen;
        logic [31:0] a;

        repeat (3) @(negedge clk);
        check("reset_result", result, 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_e", 32'(enable_op), 32'd0);
        check("reset_rw", 32'(read_write), 32'd0);
        check("reset_rs", 32'(register_select), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        load_bytes(8'h41, 8'h00, 8'h00, 8'h00);
        issue(32'd1, 0, 1'b0, 1'b0);
        load_bytes(8'h8C, 8'h00, 8'h00, 8'h00);
        issue(32'd0, 0, 1'b0, 1'b0);
        load_bytes(8'h5A, 8'h00, 8'h00, 8'h00);
        issue(32'd1, 10, 1'b0, 1'b0);
        load_bytes(8'h3C, 8'h00, 8'h00, 8'h00);
        issue(32'd0, 0, 1'b1, 1'b1);
        load_bytes(8'hC3, 8'h00, 8'h00, 8'h00);
        issue(32'd1, 0, 1'b0, 1'b0);
        load_bytes(8'h85, 8'hA0, 8'hFF, 8'h05);
        issue(32'd2, 0, 1'b0, 1'b0);
        load_bytes(8'h80, 8'h81, 8'h82, 8'h83);
        issue(32'd2, 0, 1'b0, 1'b0);

        // Abort a read with reset while E is high
        load_bytes(8'h33, 8'h00, 8'h00, 8'h00);
        e = model(32'd1, 0);
        exp_q.push_back(e);
        start = 1'b1;
        dataA = 32'd1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (enable_op) seen = 1'b1;
        end
        check("reach_pulse", 32'(enable_op), 32'd1);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        byte_q.delete();
        @(posedge clk);
        #1;
        check("abort_e", 32'(enable_op), 32'd0);
        check("abort_rw", 32'(read_write), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", result, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        load_bytes(8'h7E, 8'h00, 8'h00, 8'h00);
        issue(32'd1, 0, 1'b0, 1'b0);

        for (int t = 0; t < 20; t++) begin
            rand_bytes();
            a = $urandom;
            a[1:0] = 2'($urandom_range(0, 3));
            issue(a,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0,
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 2) == 0));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        finish_now();
    end

endmodule
`default_nettype wire
